// File: rtl/data_ram_responder.sv
// Word-addressed data RAM with a request/ready handshake for the MEM stage.
// Optional macro DRAM_WAIT_EN inserts WAIT_CYCLES wait states per access.
module data_ram_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        ram_ready,
    output logic        ram_error
);

    localparam int unsigned LP_WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DRAM_WAIT_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_oor;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [0:LP_WORDS-1];

    logic [DEPTH_LOG2-1:0]   w_req_idx;
    logic                    w_req_oor;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_oor;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic                    w_commit;
    logic                    w_is_write;
    logic                    w_unused_addr_lsb;

    assign w_req_idx         = ram_addr[DEPTH_LOG2+1:2];
    assign w_req_oor         = |ram_addr[31:DEPTH_LOG2+2];
    assign w_unused_addr_lsb = ^ram_addr[1:0];

`ifdef DRAM_WAIT_EN
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && ram_en && LP_WAIT != 4'd0) begin
            r_cnt <= LP_WAIT - 4'd1;
        end else if (r_state == BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
`else
    logic [3:0] w_unused_wait;
    assign w_unused_wait = 4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (ram_en) begin
`ifdef DRAM_WAIT_EN
                    w_state_nx = (LP_WAIT == 4'd0) ? DONE : BUSY;
`else
                    w_state_nx = DONE;
`endif
                end
            end
`ifdef DRAM_WAIT_EN
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx = DONE;
                end
            end
`endif
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && ram_en) begin
            r_idx   <= w_req_idx;
            r_oor   <= w_req_oor;
            r_be    <= ram_write_en;
            r_wdata <= ram_write_data;
        end
    end

    // With no wait states the commit edge is also the accept edge, so the
    // access fields come straight from the inputs while still in IDLE.
    assign w_idx      = (r_state == IDLE) ? w_req_idx      : r_idx;
    assign w_oor      = (r_state == IDLE) ? w_req_oor      : r_oor;
    assign w_be       = (r_state == IDLE) ? ram_write_en   : r_be;
    assign w_wdata    = (r_state == IDLE) ? ram_write_data : r_wdata;
    assign w_is_write = |w_be;
    assign w_commit   = (r_state != DONE) && (w_state_nx == DONE) && !rst;

    always_ff @(posedge clk) begin
        if (w_commit && w_is_write && !w_oor) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_commit && !w_is_write) begin
            r_rdata <= w_oor ? '0 : r_mem[w_idx];
        end
    end

    assign ram_read_data = r_rdata;
    assign ram_ready     = (r_state == DONE);
    assign ram_error     = (r_state == DONE) && r_oor;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder with a cycle-level reference model;
// follows DRAM_WAIT_EN to pick the expected wait count.
module tb_data_ram_responder;

`ifdef DRAM_WAIT_EN
    localparam int unsigned W = 2;
`else
    localparam int unsigned W = 0;
`endif

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ready;
    logic        ram_error;

    data_ram_responder #(
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .ram_ready      (ram_ready),
        .ram_error      (ram_error)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;

    // Reference model: storage words, held read word, one pending access.
    logic [31:0] m_mem [1024];
    logic [31:0] m_rdata     = '0;
    bit          pend_valid  = 1'b0;
    int unsigned pend_cycle  = 0;
    logic [31:0] pend_addr;
    logic [3:0]  pend_be;
    logic [31:0] pend_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic        exp_rdy;
        logic        exp_err;
        int unsigned idx;
        exp_rdy = 1'b0;
        exp_err = 1'b0;
        if (pend_valid && cyc == pend_cycle) begin
            exp_rdy = 1'b1;
            if (pend_addr >= 32'h1000) begin
                exp_err = 1'b1;
                if (pend_be == 4'b0000) m_rdata = '0;
            end else begin
                idx = (pend_addr / 4) % 1024;
                if (pend_be == 4'b0000) begin
                    m_rdata = m_mem[idx];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (pend_be[b]) m_mem[idx][8*b +: 8] = pend_wdata[8*b +: 8];
                end
            end
            pend_valid = 1'b0;
        end
        check("ram_ready", {31'd0, ram_ready}, {31'd0, exp_rdy});
        check("ram_error", {31'd0, ram_error}, {31'd0, exp_err});
        check("ram_read_data", ram_read_data, m_rdata);
    end

    task automatic access(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input bit drop,
                          output logic [31:0] rd, output logic err, output int lat);
        int unsigned req;
        bit          seen;
        @(posedge clk); #1;
        ram_en         = 1'b1;
        ram_addr       = addr;
        ram_write_en   = be;
        ram_write_data = wdata;
        req            = cyc;
        pend_addr      = {addr[31:2], 2'b00};
        pend_be        = be;
        pend_wdata     = wdata;
        pend_cycle     = req + 1 + W;
        pend_valid     = 1'b1;
        seen = 1'b0;
        rd   = '0;
        err  = 1'b0;
        lat  = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk); #1;
            if (drop && n == 0) begin
                ram_en         = 1'b0;
                ram_addr       = $urandom;
                ram_write_en   = 4'($urandom);
                ram_write_data = $urandom;
            end
            if (ram_ready) begin
                seen = 1'b1;
                rd   = ram_read_data;
                err  = ram_error;
                lat  = int'(cyc - req);
            end
        end
        ram_en = 1'b0;
        if (!seen) begin
            vectors++;
            miscompares++;
            pend_valid = 1'b0;
            $display("FAIL ready_timeout: no ram_ready for addr %h within 50 cycles", addr);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;

        rst            = 1'b1;
        ram_en         = 1'b0;
        ram_write_en   = '0;
        ram_addr       = '0;
        ram_write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", ram_read_data, 32'h0);
        check("reset_ready", {31'd0, ram_ready}, 32'h0);
        check("reset_error", {31'd0, ram_error}, 32'h0);
        rst = 1'b0;

        access(32'h0000_0000, 4'b1111, 32'hCAFEF00D, 1'b0, rd, err, lat);
        access(32'h0000_0010, 4'b1111, 32'hDEADBEEF, 1'b0, rd, err, lat);
        check("write_latency", lat, 1 + W);
        access(32'h0000_0010, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("read_latency", lat, 1 + W);
        check("read_deadbeef", rd, 32'hDEADBEEF);

        access(32'h0000_0020, 4'b1111, 32'h11223344, 1'b0, rd, err, lat);
        access(32'h0000_0020, 4'b0100, 32'h00AA0000, 1'b0, rd, err, lat);
        check("write_keeps_rdata", rd, 32'hDEADBEEF);
        access(32'h0000_0020, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("partial_write", rd, 32'h11AA3344);

        access(32'h0000_1000, 4'b1111, 32'hFFFFFFFF, 1'b0, rd, err, lat);
        check("oor_write_err", {31'd0, err}, 32'h1);
        access(32'h0000_1000, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("oor_read_err", {31'd0, err}, 32'h1);
        check("oor_read_data", rd, 32'h0);
        access(32'h0000_0000, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("word0_unchanged", rd, 32'hCAFEF00D);
        check("inrange_err", {31'd0, err}, 32'h0);

        access(32'h0000_0040, 4'b1111, 32'h12345678, 1'b0, rd, err, lat);
        @(posedge clk); #1;
        ram_en         = 1'b1;
        ram_addr       = 32'h0000_0040;
        ram_write_en   = 4'b1111;
        ram_write_data = 32'h55555555;
        if (W > 0) begin
            pend_addr  = 32'h0000_0040;
            pend_be    = 4'b1111;
            pend_wdata = 32'h55555555;
            pend_cycle = cyc + 1 + W;
            pend_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst        = 1'b1;
        ram_en     = 1'b0;
        pend_valid = 1'b0;
        m_rdata    = '0;
        #1;
        check("midreset_rdata", ram_read_data, 32'h0);
        check("midreset_ready", {31'd0, ram_ready}, 32'h0);
        check("midreset_error", {31'd0, ram_error}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(32'h0000_0040, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("reset_discards_write", rd, 32'h12345678);

        access(32'h0000_0080, 4'b1111, 32'hA5A5C3C3, 1'b1, rd, err, lat);
        access(32'h0000_0080, 4'b0000, 32'h0, 1'b1, rd, err, lat);
        check("drop_en_read", rd, 32'hA5A5C3C3);

        access(32'h0000_0FFC, 4'b1111, 32'h0BADCAFE, 1'b0, rd, err, lat);
        access(32'h0000_0FFC, 4'b0001, 32'h000000EE, 1'b0, rd, err, lat);
        access(32'h0000_0FFC, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("last_word", rd, 32'h0BADCAEE);
        check("last_word_err", {31'd0, err}, 32'h0);
        access(32'h0000_0013, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("addr_lsb_ignored", rd, 32'hDEADBEEF);
        access(32'h8000_0010, 4'b0000, 32'h0, 1'b0, rd, err, lat);
        check("high_bit_oor", {31'd0, err}, 32'h1);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
